// File: rtl/seg_display_ctrl_pkg.sv
// Shared types, glyph codes and helpers for the
// seven-segment display controller.
package seg_display_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t GLYPH_BLANK = 5'd16;
  localparam glyph_t GLYPH_DASH  = 5'd17;
  localparam glyph_t GLYPH_E     = 5'd18;

  typedef enum logic [1:0] {
    MODE_DEC = 2'b00,
    MODE_HEX = 2'b01,
    MODE_RAW = 2'b10,
    MODE_ERR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_FORMAT,
    S_COMMIT
  } state_e;

  function automatic int dec_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

  // Active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph_to_seg(input glyph_t g);
    logic [6:0] s;
    case (g)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      5'd10:   s = 7'h77;
      5'd11:   s = 7'h7C;
      5'd12:   s = 7'h39;
      5'd13:   s = 7'h5E;
      5'd14:   s = 7'h79;
      5'd15:   s = 7'h71;
      5'd17:   s = 7'h40;
      5'd18:   s = 7'h79;
      default: s = 7'h00;
    endcase
    return ~s;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Load handshake bundle between a value source
// and the display controller.
interface seg_display_ctrl_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 8
);
  logic                    load_valid;
  logic                    load_ready;
  logic [1:0]              load_mode;
  logic [DATA_W-1:0]       load_data;
  logic [4*NUM_DIGITS-1:0] load_digits;

  modport master (
    output load_valid,
    output load_mode,
    output load_data,
    output load_digits,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_mode,
    input  load_data,
    input  load_digits,
    output load_ready
  );
endinterface

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Iterative double-dabble: one input bit per
// clock, DATA_W clocks after start.
module seg_bin2bcd #(
  parameter int DATA_W     = 16,
  parameter int DEC_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [DATA_W-1:0]       i_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*DEC_DIGITS-1:0] o_bcd
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = 4 * DEC_DIGITS;

  logic [DATA_W-1:0] r_bin;
  logic [BW-1:0]     r_bcd;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     w_adj;

  // Add 3 to every BCD digit that is 5 or more
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one bit per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(DATA_W);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[BW-2:0], r_bin[DATA_W-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment controller: load FSM,
// glyph formatter, double-buffered display and scanner.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 16384,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_ctrl_if.slave     bus,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [2:0]            brightness,
  output logic                  commit,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out
);
  localparam int DEC_DIGITS = dec_digits(DATA_W);
  localparam int HEX_N  = (DATA_W + 3) / 4;
  localparam int MAXD   = (NUM_DIGITS > DEC_DIGITS) ? NUM_DIGITS : DEC_DIGITS;
  localparam int MAXH   = (NUM_DIGITS > HEX_N) ? NUM_DIGITS : HEX_N;
  localparam int BCD_PW = 4 * MAXD;
  localparam int HEX_PW = 4 * MAXH;
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int DIG_W  = $clog2(NUM_DIGITS);
  localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_e r_state;
  state_e w_next;

  mode_e                   r_mode;
  logic [DATA_W-1:0]       r_data;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic                    r_neg;

  glyph_t r_stage [NUM_DIGITS];
  glyph_t r_disp  [NUM_DIGITS];
  glyph_t w_fmt   [NUM_DIGITS];

  logic [SLOT_W-1:0]     r_slot;
  logic [DIG_W-1:0]      r_digit;
  logic [BLK_W-1:0]      r_blink_cnt;
  logic                  r_blink_phase;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                    w_accept;
  logic                    w_start;
  logic [DATA_W-1:0]       w_mag;
  logic                    w_busy;
  logic                    w_done;
  logic [4*DEC_DIGITS-1:0] w_bcd;
  logic [BCD_PW-1:0]       w_bcd_pad;
  logic [HEX_PW-1:0]       w_hex_pad;
  int                      w_sig;
  int                      w_need;
  logic                    w_is_err;
  logic                    w_is_dec;
  logic                    w_is_hex;
  logic                    w_is_raw;
  logic                    w_lit;
  glyph_t                  w_glyph;

  assign bus.load_ready = (r_state == S_IDLE);
  assign w_accept = bus.load_valid && bus.load_ready;
  assign w_start  = w_accept && (bus.load_mode == MODE_DEC);
  assign w_mag    = bus.load_data[DATA_W-1]
                  ? (DATA_W'(0) - bus.load_data)
                  : bus.load_data;

  seg_bin2bcd #(
    .DATA_W     (DATA_W),
    .DEC_DIGITS (DEC_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_bin   (w_mag),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  assign w_bcd_pad = BCD_PW'(w_bcd);
  assign w_hex_pad = HEX_PW'(r_data);

  function automatic glyph_t err_glyph(input int i);
    if (i == 0)
      return GLYPH_E;
    else if (i <= 3)
      return GLYPH_DASH;
    else
      return GLYPH_BLANK;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = (bus.load_mode == MODE_DEC) ? S_CONVERT : S_FORMAT;
      S_CONVERT:
        if (w_done || !w_busy) w_next = S_FORMAT;
      S_FORMAT: w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign commit = (r_state == S_COMMIT);

  // Capture the request on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= MODE_DEC;
      r_data   <= '0;
      r_digits <= '0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_mode   <= mode_e'(bus.load_mode);
      r_data   <= bus.load_data;
      r_digits <= bus.load_digits;
      r_neg    <= bus.load_data[DATA_W-1];
    end
  end

  // Formatter: glyphs for every digit from mode and data
  always_comb begin
    w_sig = 1;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (w_bcd_pad[4*i +: 4] != 4'd0) w_sig = i + 1;
    end
    w_need   = w_sig + (r_neg ? 1 : 0);
    w_is_err = (r_mode == MODE_ERR)
            || ((r_mode == MODE_DEC) && (w_need > NUM_DIGITS));
    w_is_dec = (r_mode == MODE_DEC) && !w_is_err;
    w_is_hex = (r_mode == MODE_HEX);
    w_is_raw = (r_mode == MODE_RAW);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_fmt[i] = GLYPH_BLANK;
      unique case (1'b1)
        w_is_err: w_fmt[i] = err_glyph(i);
        w_is_dec: begin
          if (i < w_sig)
            w_fmt[i] = {1'b0, w_bcd_pad[4*i +: 4]};
          else if (r_neg && (i == w_sig))
            w_fmt[i] = GLYPH_DASH;
        end
        w_is_hex: begin
          if (i < HEX_N)
            w_fmt[i] = {1'b0, w_hex_pad[4*i +: 4]};
        end
        w_is_raw: begin
          if (r_digits[4*i +: 4] <= 4'd9)
            w_fmt[i] = {1'b0, r_digits[4*i +: 4]};
          else if (r_digits[4*i +: 4] == 4'hA)
            w_fmt[i] = GLYPH_DASH;
        end
        default: w_fmt[i] = GLYPH_BLANK;
      endcase
    end
  end

  // Staging fills in FORMAT, display swaps whole in COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_stage[i] <= GLYPH_BLANK;
        r_disp[i]  <= GLYPH_BLANK;
      end
    end else begin
      if (r_state == S_FORMAT) r_stage <= w_fmt;
      if (r_state == S_COMMIT) r_disp  <= r_stage;
    end
  end

  // Slot and digit scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_digit <= '0;
    end else begin
      r_slot <= r_slot + 1'b1;
      if (r_slot == '1) begin
        if (r_digit == DIG_W'(NUM_DIGITS - 1))
          r_digit <= '0;
        else
          r_digit <= r_digit + 1'b1;
      end
    end
  end

  // Blink half-period timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Committing glyphs show on the same edge the buffer swaps
  assign w_glyph = (r_state == S_COMMIT) ? r_stage[r_digit]
                                         : r_disp[r_digit];

  assign w_lit = (r_slot != '0)
              && (r_slot[SLOT_W-1 -: 3] <= brightness)
              && !(blink_mask[r_digit] && r_blink_phase);

  // Anode and segment output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
    end else if (w_lit) begin
      r_an  <= ~(NUM_DIGITS'(1) << r_digit);
      r_seg <= glyph_to_seg(w_glyph);
    end else begin
      r_an  <= '1;
      r_seg <= 7'h7F;
    end
  end

  assign an_out  = r_an;
  assign seg_out = r_seg;
endmodule
